// File: rtl/resp_mux_lock.sv
// resp_mux_lock: N-to-1 slave response mux with a per-transaction select lock.
// Reports unmapped selects and timeouts. Optional macro: RESP_MUX_REG_OUT_EN.

module resp_mux_lock #(
   parameter int NUM_SLAVES = 3,
   parameter int WIDTH      = 1,
   parameter int SEL_W      = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [SEL_W-1:0]            sel_in,
   input  logic                        sel_load,
   input  logic                        txn_done,
   input  logic [NUM_SLAVES*WIDTH-1:0] in_data,
   input  logic [NUM_SLAVES-1:0]       in_valid,
   output logic [WIDTH-1:0]            out_data,
   output logic                        out_valid,
   output logic                        busy,
   output logic [SEL_W-1:0]            sel_active,
   output logic                        err,
   output logic [1:0]                  err_code
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(TIMEOUT - 1);
   localparam logic [SEL_W:0]   NS_LIM  = (SEL_W + 1)'(NUM_SLAVES);

   localparam logic [1:0] CODE_NONE  = 2'b00;
   localparam logic [1:0] CODE_UNMAP = 2'b01;
   localparam logic [1:0] CODE_TMO   = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      ERROR  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [SEL_W-1:0] sel_q;
   logic [SEL_W-1:0] sel_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [1:0]       code;
   logic [1:0]       code_nx;

   logic [WIDTH-1:0] mux_data;
   logic             mux_valid;
   logic             mapped;
   logic             tmo_hit;
   logic             act;

   // select the locked slave's response lines
   always_comb begin
      mux_data  = '0;
      mux_valid = 1'b0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (sel_q == SEL_W'(k)) begin
            mux_data  = in_data[k*WIDTH +: WIDTH];
            mux_valid = in_valid[k];
         end
      end
   end

   assign mapped  = ({1'b0, sel_in} < NS_LIM);
   assign tmo_hit = (TIMEOUT > 0) && !mux_valid && (cnt == CNT_THR);
   assign act     = (state == ACTIVE);

   // next-state: lock, classify, count idle cycles, release on txn_done
   always_comb begin
      state_nx = state;
      sel_nx   = sel_q;
      cnt_nx   = cnt;
      code_nx  = code;
      unique case (state)
         IDLE: begin
            if (sel_load) begin
               cnt_nx = '0;
               if (mapped) begin
                  state_nx = ACTIVE;
                  sel_nx   = sel_in;
                  code_nx  = CODE_NONE;
               end else begin
                  state_nx = ERROR;
                  sel_nx   = '0;
                  code_nx  = CODE_UNMAP;
               end
            end
         end
         ACTIVE, ERROR: begin
            if (txn_done) begin
               cnt_nx = '0;
               if (sel_load && mapped) begin
                  state_nx = ACTIVE;
                  sel_nx   = sel_in;
                  code_nx  = CODE_NONE;
               end else if (sel_load) begin
                  state_nx = ERROR;
                  sel_nx   = '0;
                  code_nx  = CODE_UNMAP;
               end else begin
                  state_nx = IDLE;
                  sel_nx   = '0;
                  code_nx  = CODE_NONE;
               end
            end else if (state == ACTIVE) begin
               if (tmo_hit) begin
                  state_nx = ERROR;
                  code_nx  = CODE_TMO;
               end else if (mux_valid) begin
                  cnt_nx = '0;
               end else if (cnt != CNT_MAX) begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            state_nx = IDLE;
            sel_nx   = '0;
            cnt_nx   = '0;
            code_nx  = CODE_NONE;
         end
      endcase
   end

   // state, lock, counter and error code registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         sel_q <= '0;
         cnt   <= '0;
         code  <= CODE_NONE;
      end else begin
         state <= state_nx;
         sel_q <= sel_nx;
         cnt   <= cnt_nx;
         code  <= code_nx;
      end
   end

`ifdef RESP_MUX_REG_OUT_EN
   logic [WIDTH-1:0] od_q;
   logic             ov_q;

   // one-cycle registered return path; zero outside ACTIVE
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         od_q <= '0;
         ov_q <= 1'b0;
      end else begin
         od_q <= act ? mux_data : '0;
         ov_q <= act & mux_valid;
      end
   end

   assign out_data  = od_q;
   assign out_valid = ov_q;
`else
   assign out_data  = act ? mux_data : '0;
   assign out_valid = act & mux_valid;
`endif

   assign busy       = (state != IDLE);
   assign err        = (state == ERROR);
   assign err_code   = code;
   assign sel_active = sel_q;

endmodule

// File: doc/resp_mux_lock.md
Name: resp_mux_lock

Overview:
- Parametrised N-to-1 slave response multiplexer for the serial bus, replacing the fixed 3-input combinational mux on the slave-to-master return path.
- Latches the slave select when the address phase completes and holds it until the transaction ends, so decoder changes mid-transaction cannot glitch the return path.
- Flags unmapped selects and reports slaves that stop responding (timeout).
- Sits between the slave response lines and the master-side response port, driven by the address decoder and the arbiter.

Parameters:
- NUM_SLAVES, 3, number of slave response inputs (2..16).
- WIDTH, 1, response bits per slave per cycle (serial data plus any sideband).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_SLAVES.
- TIMEOUT, 255, maximum consecutive cycles without in_valid from the locked slave; 0 disables the timeout.

Ports:
- clk  in  1  bus clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- sel_in  in  SEL_W  slave index from the address decoder.
- sel_load  in  1  one-cycle pulse; latch sel_in.
- txn_done  in  1  one-cycle pulse from the arbiter; the transaction has ended.
- in_data  in  NUM_SLAVES*WIDTH  slave responses; slave k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  NUM_SLAVES  per-slave response valid.
- out_data  out  WIDTH  selected response.
- out_valid  out  1  selected response valid.
- busy  out  1  a select is locked (ACTIVE or ERROR state).
- sel_active  out  SEL_W  currently latched index.
- err  out  1  error present for the current transaction.
- err_code  out  2  2'b00 none, 2'b01 unmapped select, 2'b10 timeout.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; sel_active=0; timeout counter=0; out_data=0; out_valid=0; busy=0; err=0; err_code=0.
- States: IDLE, ACTIVE, ERROR. All state, sel_active, counter and err_code are registers.
- IDLE: out_data=0, out_valid=0. On sel_load:
  - sel_in < NUM_SLAVES: latch sel_in, go to ACTIVE.
  - otherwise: go to ERROR with err_code=01.
  - txn_done alone is ignored.
- ACTIVE:
  - out_data = in_data slice of sel_active; out_valid = in_valid[sel_active]. Combinational, zero latency from the inputs.
  - Counter increments each cycle in_valid[sel_active]=0 and clears on any cycle it is 1.
  - TIMEOUT>0 and counter==TIMEOUT-1 with valid still low: go to ERROR with err_code=10 on the next edge. The counter saturates and never wraps.
  - sel_load without txn_done is ignored; the lock holds.
- ERROR: out_valid=0, out_data=0, err=1, busy=1. Held until txn_done.
- txn_done in ACTIVE or ERROR: next state IDLE; clear counter, err_code and sel_active.
- txn_done and sel_load in the same cycle, in ACTIVE or ERROR: back-to-back transfer. The new select is latched and classified exactly as from IDLE, and the counter is cleared; there is no IDLE bubble.
- Timeout threshold and txn_done in the same cycle: txn_done wins; no error is reported.
- busy=1 exactly when state is ACTIVE or ERROR. err=1 exactly when state is ERROR.
- Reset asserted mid-transaction drops to IDLE immediately with every output zero.

Optional Feature:
- Macro: RESP_MUX_REG_OUT_EN.
- Defined:
  - out_data and out_valid are registered, adding 1 cycle of latency. Reset value 0.
  - The register captures the ACTIVE-state mux result and captures 0 in IDLE/ERROR.
  - err and busy stay unregistered relative to state.
  - The timeout counter still uses the unregistered in_valid.
- Undefined: combinational path exactly as described in Behaviour.

Test Plan (NUM_SLAVES=4, SEL_W=2, WIDTH=8, TIMEOUT=16):
- Lock and hold: sel_load with sel_in=2; slave2 drives 8'hA5 valid; sel_in changes to 1 mid-transfer -> out_data=8'hA5, out_valid=1, sel_active stays 2, busy=1 until the cycle after txn_done.
- Unmapped select: NUM_SLAVES=3 build, sel_load with sel_in=3 -> next cycle err=1, err_code=01, out_valid=0 while slave inputs toggle; txn_done -> err=0, busy=0.
- Timeout: lock slave 1 with in_valid[1]=0 -> after exactly 16 low cycles err_code=10. Repeat with a single valid pulse at cycle 10 -> counter restarts and no error by cycle 16.
- Back-to-back: txn_done and sel_load(sel_in=0) in the same cycle while locked on slave 3 -> next cycle sel_active=0, busy stays 1, out_data follows slave 0.
- Reset mid-transfer: rstn low while ACTIVE with out_valid=1 -> out_valid, busy and err are 0 within the same cycle, without waiting for a clock edge.
- Timeout vs done: txn_done on the threshold cycle -> IDLE, err never asserts. With RESP_MUX_REG_OUT_EN defined, rerun the first scenario and check out_data=8'hA5 one cycle later.
